// File: rtl/apb_multi_timer_if.sv
// APB3 slave-side bus bundle for apb_multi_timer: 8-bit byte address, 32-bit data.
interface apb_multi_timer_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_multi_timer.sv
// Multi-channel APB down-counter timer: NUM_CH channels sharing one prescaler,
// each with periodic/one-shot mode, raw status, enable mask and registered interrupt.
module apb_multi_timer #(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 32,
  parameter int PRE_WIDTH = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  apb_multi_timer_if.slave  apb,
  output logic [NUM_CH-1:0] TIMINT,
  output logic              IRQ
);

  localparam logic [PRE_WIDTH-1:0] PRE_ONE = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  logic [2:0] ch_sel;
  logic [1:0] reg_sel;
  logic       is_ch;
  logic       is_mis;
  logic       is_pre;
  logic       ch_valid;
  logic       addr_err;
  logic       access;
  logic       wr_ok;
  logic       rd_ok;
  logic       unused_bits;

  assign ch_sel   = apb.PADDR[6:4];
  assign reg_sel  = apb.PADDR[3:2];
  assign is_ch    = !apb.PADDR[7];
  assign is_mis   = (apb.PADDR[7:2] == 6'h20);
  assign is_pre   = (apb.PADDR[7:2] == 6'h21);
  assign ch_valid = ({1'b0, ch_sel} < 4'(NUM_CH));

  assign unused_bits = ^{apb.PADDR[1:0], apb.PWDATA};

  always_comb begin
    addr_err = 1'b1;
    if (is_ch) begin
      addr_err = !ch_valid || (apb.PWRITE && reg_sel == 2'd1);
    end else if (is_mis) begin
      addr_err = apb.PWRITE;
    end else if (is_pre) begin
      addr_err = 1'b0;
    end
  end

  assign access      = apb.PSEL & apb.PENABLE;
  assign wr_ok       = access & apb.PWRITE & !addr_err;
  assign rd_ok       = access & !apb.PWRITE & !addr_err;
  assign apb.PSLVERR = access & addr_err;
  assign apb.PREADY  = 1'b1;

  // Shared prescaler: tick when the counter reaches PRESCALE, then wrap.
  logic [PRE_WIDTH-1:0] pre_reg;
  logic [PRE_WIDTH-1:0] pcnt_reg;
  logic                 tick;
  logic                 pre_wr;

  assign tick   = (pcnt_reg == pre_reg);
  assign pre_wr = wr_ok & is_pre;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      pre_reg  <= '0;
      pcnt_reg <= '0;
    end else if (pre_wr) begin
      pre_reg  <= apb.PWDATA[PRE_WIDTH-1:0];
      pcnt_reg <= '0;
    end else if (tick) begin
      pcnt_reg <= '0;
    end else begin
      pcnt_reg <= pcnt_reg + PRE_ONE;
    end
  end

  logic [NUM_CH-1:0] ris_vec;
  logic [NUM_CH-1:0] inten_vec;
  logic [NUM_CH-1:0] timint_vec;
  logic [NUM_CH-1:0] mis;
  logic [31:0]       ch_rdata [NUM_CH];

  assign mis = ris_vec & inten_vec;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : gen_ch
      logic [CNT_WIDTH-1:0] load_reg;
      logic [CNT_WIDTH-1:0] value_reg;
      logic                 en_reg;
      logic                 inten_reg;
      logic                 mode_reg;
      logic                 ris_reg;
      logic                 timint_reg;
      logic                 sel;
      logic                 load_wr;
      logic                 ctrl_wr;
      logic                 ris_clr;
      logic                 count;
      logic                 fire;

      assign sel     = wr_ok & is_ch & (ch_sel == 3'(gi));
      assign load_wr = sel & (reg_sel == 2'd0);
      assign ctrl_wr = sel & (reg_sel == 2'd2);
      assign ris_clr = sel & (reg_sel == 2'd3) & apb.PWDATA[0];
      // A LOAD write or a CTRL write that drops EN pre-empts this cycle's tick.
      assign count   = tick & en_reg & !load_wr & !(ctrl_wr & !apb.PWDATA[0]);
      assign fire    = count & (value_reg == '0);

      always_ff @(posedge PCLK) begin
        if (PRESET) begin
          load_reg   <= '0;
          value_reg  <= '0;
          en_reg     <= 1'b0;
          inten_reg  <= 1'b0;
          mode_reg   <= 1'b0;
          ris_reg    <= 1'b0;
          timint_reg <= 1'b0;
        end else begin
          if (load_wr) begin
            load_reg  <= apb.PWDATA[CNT_WIDTH-1:0];
            value_reg <= apb.PWDATA[CNT_WIDTH-1:0];
          end else if (fire) begin
            value_reg <= mode_reg ? '0 : load_reg;
          end else if (count) begin
            value_reg <= value_reg - CNT_ONE;
          end

          if (ctrl_wr) begin
            en_reg    <= apb.PWDATA[0];
            inten_reg <= apb.PWDATA[1];
            mode_reg  <= apb.PWDATA[2];
          end
          if (fire && mode_reg) begin
            en_reg <= 1'b0;
          end

          if (fire) begin
            ris_reg <= 1'b1;
          end else if (ris_clr) begin
            ris_reg <= 1'b0;
          end

          timint_reg <= ris_reg & inten_reg;
        end
      end

      always_comb begin
        ch_rdata[gi] = '0;
        case (reg_sel)
          2'd0:    ch_rdata[gi] = 32'(load_reg);
          2'd1:    ch_rdata[gi] = 32'(value_reg);
          2'd2:    ch_rdata[gi] = {29'd0, mode_reg, inten_reg, en_reg};
          default: ch_rdata[gi] = {31'd0, ris_reg};
        endcase
      end

      assign ris_vec[gi]    = ris_reg;
      assign inten_vec[gi]  = inten_reg;
      assign timint_vec[gi] = timint_reg;
    end
  endgenerate

  logic irq_reg;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      irq_reg <= 1'b0;
    end else begin
      irq_reg <= |mis;
    end
  end

  assign TIMINT = timint_vec;
  assign IRQ    = irq_reg;

  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    if (rd_ok) begin
      if (is_ch) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch_sel == 3'(i)) begin
            rdata = ch_rdata[i];
          end
        end
      end else if (is_mis) begin
        rdata = 32'(mis);
      end else begin
        rdata = 32'(pre_reg);
      end
    end
  end

  assign apb.PRDATA = rdata;

endmodule

// File: tb/tb_apb_multi_timer.sv
// Self-checking bench for apb_multi_timer: directed scenarios plus randomized
// register traffic checked against a register-level behavioural model.
module tb_apb_multi_timer;

  logic PCLK = 1'b0;
  logic PRESET = 1'b1;
  always #5 PCLK = ~PCLK;

  apb_multi_timer_if bus ();
  apb_multi_timer_if bus2 ();

  logic [3:0] timint;
  logic       irq;
  logic [1:0] timint2;
  logic       irq2;

  apb_multi_timer #(.NUM_CH(4), .CNT_WIDTH(32), .PRE_WIDTH(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .apb(bus), .TIMINT(timint), .IRQ(irq)
  );

  apb_multi_timer #(.NUM_CH(2), .CNT_WIDTH(16), .PRE_WIDTH(8)) dut2 (
    .PCLK(PCLK), .PRESET(PRESET), .apb(bus2), .TIMINT(timint2), .IRQ(irq2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural register-level model of the 4-channel instance.
  int unsigned m_load [4];
  int unsigned m_value[4];
  bit          m_en   [4];
  bit          m_inten[4];
  bit          m_mode [4];
  bit          m_ris  [4];
  int unsigned m_pre  = 0;
  int unsigned m_pcnt = 0;
  bit [3:0]    m_timint = '0;
  bit          m_irq = 1'b0;

  function automatic bit m_err(input logic [7:0] a, input bit w, input int nch);
    int c;
    c = int'(a[6:4]);
    if (!a[7]) begin
      if (c >= nch) return 1'b1;
      if (w && a[3:2] == 2'd1) return 1'b1;
      return 1'b0;
    end
    if (a[7:2] == 6'h20) return w;
    if (a[7:2] == 6'h21) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    int c;
    logic [31:0] r;
    c = int'(a[6:4]);
    r = '0;
    if (m_err(a, 1'b0, 4)) return '0;
    if (!a[7]) begin
      case (a[3:2])
        2'd0:    r = m_load[c];
        2'd1:    r = m_value[c];
        2'd2:    r = {29'd0, m_mode[c], m_inten[c], m_en[c]};
        default: r = {31'd0, m_ris[c]};
      endcase
    end else if (a[7:2] == 6'h20) begin
      for (int i = 0; i < 4; i++) r[i] = m_ris[i] & m_inten[i];
    end else begin
      r = m_pre;
    end
    return r;
  endfunction

  task automatic model_step();
    bit tick;
    bit wr;
    logic [7:0]  a;
    logic [31:0] d;
    int c;
    if (PRESET) begin
      for (int i = 0; i < 4; i++) begin
        m_load[i] = 0; m_value[i] = 0; m_en[i] = 0;
        m_inten[i] = 0; m_mode[i] = 0; m_ris[i] = 0;
      end
      m_pre = 0; m_pcnt = 0; m_timint = '0; m_irq = 0;
      return;
    end
    a    = bus.PADDR;
    d    = bus.PWDATA;
    c    = int'(a[6:4]);
    tick = (m_pcnt == m_pre);
    wr   = bus.PSEL && bus.PENABLE && bus.PWRITE && !m_err(a, 1'b1, 4);
    m_irq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_timint[i] = m_ris[i] & m_inten[i];
      m_irq       = m_irq | m_timint[i];
    end
    for (int i = 0; i < 4; i++) begin
      bit wl, wc, wrs, cnt, fire, old_mode;
      wl  = wr && !a[7] && c == i && a[3:2] == 2'd0;
      wc  = wr && !a[7] && c == i && a[3:2] == 2'd2;
      wrs = wr && !a[7] && c == i && a[3:2] == 2'd3 && d[0];
      cnt = tick && m_en[i] && !wl && !(wc && !d[0]);
      fire = cnt && m_value[i] == 0;
      old_mode = m_mode[i];
      if (wl) begin m_load[i] = d; m_value[i] = d; end
      if (wc) begin m_en[i] = d[0]; m_inten[i] = d[1]; m_mode[i] = d[2]; end
      if (wrs) m_ris[i] = 1'b0;
      if (cnt) begin
        if (fire) begin
          m_ris[i] = 1'b1;
          if (old_mode) m_en[i] = 1'b0;
          else m_value[i] = m_load[i];
        end else begin
          m_value[i] = m_value[i] - 1;
        end
      end
    end
    if (wr && a[7:2] == 6'h21) begin
      m_pre = d[15:0]; m_pcnt = 0;
    end else if (tick) begin
      m_pcnt = 0;
    end else begin
      m_pcnt = m_pcnt + 1;
    end
  endtask

  always @(posedge PCLK) model_step();

  // Bus tasks start and end 1 time unit after a rising edge.
  task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output bit err);
    bus.PSEL = 1'b1; bus.PWRITE = 1'b1; bus.PADDR = a; bus.PWDATA = d; bus.PENABLE = 1'b0;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    #1 err = bus.PSLVERR;
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] rd, output bit err,
                          output logic [31:0] exp_rd, output bit exp_err);
    bus.PSEL = 1'b1; bus.PWRITE = 1'b0; bus.PADDR = a; bus.PENABLE = 1'b0;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    #1;
    rd = bus.PRDATA; err = bus.PSLVERR;
    exp_rd = m_read(a); exp_err = m_err(a, 1'b0, 4);
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  task automatic stream_begin(input logic [7:0] a);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b1; bus.PWRITE = 1'b0; bus.PADDR = a;
    #1;
  endtask

  task automatic stream_end();
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge PCLK); #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    logic [31:0] rd, er;
    bit err, ee;
    for (int ch = 0; ch < 4; ch++) begin
      for (int r = 0; r < 4; r++) begin
        apb_read(8'(ch * 16 + r * 4), rd, err, er, ee);
        n_tests++;
        if (rd !== 32'd0 || err !== 1'b0) begin
          n_fail++;
          $display("FAIL %s reg ch%0d+%0d: got %h err %b, need 0 err 0", tag, ch, r * 4, rd, err);
        end
      end
    end
    apb_read(8'h80, rd, err, er, ee);
    n_tests++;
    if (rd !== 32'd0) begin n_fail++; $display("FAIL %s MIS: got %h need 0", tag, rd); end
    apb_read(8'h84, rd, err, er, ee);
    n_tests++;
    if (rd !== 32'd0) begin n_fail++; $display("FAIL %s PRESCALE: got %h need 0", tag, rd); end
    n_tests++;
    if (timint !== 4'd0 || irq !== 1'b0 || bus.PREADY !== 1'b1) begin
      n_fail++;
      $display("FAIL %s outputs: TIMINT %b IRQ %b PREADY %b, need 0 0 1", tag, timint, irq, bus.PREADY);
    end
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    idle(2);
    PRESET = 1'b0;
    check_all_zero("reset");
    $display("[TB] test_reset done");
  endtask

  task automatic test_periodic();
    bit err;
    logic [31:0] rd;
    apb_write(8'h00, 32'd3, err);
    apb_write(8'h08, 32'b011, err);
    stream_begin(8'h04);
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin @(posedge PCLK); #1; end
      rd = bus.PRDATA;
      n_tests++;
      if (rd !== 32'(3 - (k % 4)) || rd !== m_value[0]) begin
        n_fail++;
        $display("FAIL periodic value k=%0d: got %0d need %0d", k, rd, 3 - (k % 4));
      end
      n_tests++;
      if (timint[0] !== (k >= 5) || irq !== (k >= 5)) begin
        n_fail++;
        $display("FAIL periodic irq k=%0d: TIMINT0 %b IRQ %b need %b", k, timint[0], irq, k >= 5);
      end
      $display("[TB] periodic k=%0d value=%0d timint0=%b", k, rd, timint[0]);
    end
    stream_end();
    apb_write(8'h08, 32'd0, err);
    apb_write(8'h0C, 32'd1, err);
    idle(1);
    n_tests++;
    if (timint[0] !== 1'b0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL periodic clear: TIMINT0 %b IRQ %b need 0 0", timint[0], irq);
    end
  endtask

  task automatic test_oneshot();
    bit err, ee;
    logic [31:0] rd, er;
    int first;
    apb_write(8'h84, 32'd4, err);
    apb_write(8'h10, 32'd2, err);
    idle(1);
    apb_write(8'h18, 32'b111, err);
    first = -1;
    stream_begin(8'h1C);
    for (int k = 0; k < 30; k++) begin
      if (k > 0) begin @(posedge PCLK); #1; end
      rd = bus.PRDATA;
      if (rd[0] && first < 0) first = k;
      n_tests++;
      if (rd !== 32'(k >= 15) || rd[0] !== m_ris[1] || timint[1] !== (k >= 16)) begin
        n_fail++;
        $display("FAIL oneshot ris k=%0d: RIS %h TIMINT1 %b need %0d %b", k, rd, timint[1], k >= 15, k >= 16);
      end
    end
    stream_end();
    $display("[TB] oneshot first fire at k=%0d", first);
    n_tests++;
    if (first !== 15) begin n_fail++; $display("FAIL oneshot latency: got %0d need 15", first); end
    apb_read(8'h18, rd, err, er, ee);
    n_tests++;
    if (rd !== 32'b110) begin n_fail++; $display("FAIL oneshot ctrl: got %h need 6", rd); end
    apb_read(8'h14, rd, err, er, ee);
    n_tests++;
    if (rd !== 32'd0) begin n_fail++; $display("FAIL oneshot value: got %h need 0", rd); end
    apb_write(8'h1C, 32'd1, err);
    idle(25);
    apb_read(8'h1C, rd, err, er, ee);
    n_tests++;
    if (rd !== 32'd0 || timint[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL oneshot refire: RIS %h TIMINT1 %b need 0 0", rd, timint[1]);
    end
  endtask

  task automatic test_clear_vs_set();
    bit err, ee;
    logic [31:0] rd, er;
    apb_write(8'h84, 32'd0, err);
    apb_write(8'h20, 32'd0, err);
    apb_write(8'h28, 32'b011, err);
    idle(3);
    apb_write(8'h2C, 32'd1, err);
    apb_read(8'h2C, rd, err, er, ee);
    n_tests++;
    if (rd !== 32'd1 || rd !== er) begin n_fail++; $display("FAIL clear_vs_set ris: got %h need 1", rd); end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (timint[2] !== 1'b1 || timint !== m_timint) begin
        n_fail++;
        $display("FAIL clear_vs_set timint k=%0d: got %b need TIMINT2=1", k, timint);
      end
      idle(1);
    end
    apb_write(8'h28, 32'd0, err);
    apb_write(8'h2C, 32'd1, err);
  endtask

  task automatic test_load_vs_tick();
    bit err;
    logic [31:0] rd;
    apb_write(8'h30, 32'd50, err);
    apb_write(8'h38, 32'b001, err);
    idle(5);
    apb_write(8'h30, 32'd10, err);
    stream_begin(8'h34);
    rd = bus.PRDATA;
    n_tests++;
    if (rd !== 32'd10) begin n_fail++; $display("FAIL load_vs_tick: got %0d need 10", rd); end
    @(posedge PCLK); #1;
    rd = bus.PRDATA;
    n_tests++;
    if (rd !== 32'd9) begin n_fail++; $display("FAIL load_vs_tick next: got %0d need 9", rd); end
    stream_end();
    apb_write(8'h38, 32'd0, err);
  endtask

  task automatic test_errors();
    bit err, ee;
    logic [31:0] rd, er, v0;
    bus2.PSEL = 1'b1; bus2.PWRITE = 1'b0; bus2.PADDR = 8'h20;
    @(posedge PCLK); #1;
    bus2.PENABLE = 1'b1;
    #1;
    n_tests++;
    if (bus2.PSLVERR !== 1'b1 || bus2.PRDATA !== 32'd0) begin
      n_fail++;
      $display("FAIL err ch2 on 2ch: PSLVERR %b PRDATA %h need 1 0", bus2.PSLVERR, bus2.PRDATA);
    end
    bus2.PADDR = 8'h14;
    #1;
    n_tests++;
    if (bus2.PSLVERR !== 1'b0) begin n_fail++; $display("FAIL err ch1 on 2ch: PSLVERR %b need 0", bus2.PSLVERR); end
    @(posedge PCLK); #1;
    bus2.PSEL = 1'b0; bus2.PENABLE = 1'b0;

    apb_read(8'h04, v0, err, er, ee);
    apb_write(8'h04, 32'hDEAD, err);
    n_tests++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL err value write: PSLVERR %b need 1", err); end
    apb_read(8'h04, rd, err, er, ee);
    n_tests++;
    if (rd !== v0 || rd !== er) begin n_fail++; $display("FAIL err value kept: got %h need %h", rd, v0); end
    apb_read(8'h88, rd, err, er, ee);
    n_tests++;
    if (err !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL err unmapped: PSLVERR %b data %h need 1 0", err, rd); end
    apb_read(8'h40, rd, err, er, ee);
    n_tests++;
    if (err !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL err ch4: PSLVERR %b data %h need 1 0", err, rd); end
    apb_write(8'h80, 32'hF, err);
    n_tests++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL err mis write: PSLVERR %b need 1", err); end
  endtask

  task automatic test_masking();
    bit err, ee;
    logic [31:0] rd, er;
    apb_write(8'h3C, 32'd1, err);
    apb_write(8'h10, 32'd1, err);
    apb_write(8'h18, 32'b001, err);
    idle(10);
    apb_read(8'h1C, rd, err, er, ee);
    n_tests++;
    if (rd !== 32'd1) begin n_fail++; $display("FAIL mask ris: got %h need 1", rd); end
    apb_read(8'h80, rd, err, er, ee);
    n_tests++;
    if (rd !== 32'd0 || timint !== 4'd0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL mask outputs: MIS %h TIMINT %b IRQ %b need 0 0 0", rd, timint, irq);
    end
  endtask

  task automatic test_random();
    logic [7:0] addrs [10];
    logic [7:0]  a;
    logic [31:0] d, rd, er;
    bit err, ee, w;
    addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h80, 8'h84, 8'h00, 8'h08, 8'h0C, 8'h80};
    for (int t = 0; t < 200; t++) begin
      a = addrs[$urandom_range(0, 9)] + 8'(16 * $urandom_range(0, 3));
      if (a[7]) a = addrs[$urandom_range(4, 5)];
      if ($urandom_range(0, 15) == 0) a = 8'(4 * $urandom_range(16, 63));
      w = $urandom_range(0, 1);
      case (a[3:2])
        2'd0:    d = a[7] ? 32'($urandom_range(0, 15)) : 32'($urandom_range(0, 7));
        2'd1:    d = a[7] ? 32'($urandom_range(0, 3)) : $urandom;
        2'd2:    d = 32'($urandom_range(0, 7));
        default: d = 32'($urandom_range(0, 1));
      endcase
      if (w) begin
        ee = m_err(a, 1'b1, 4);
        apb_write(a, d, err);
        n_tests++;
        if (err !== ee) begin n_fail++; $display("FAIL rnd %0d wr %h: PSLVERR %b need %b", t, a, err, ee); end
        $display("[TB] rnd %0d wr a=%h d=%h err=%b", t, a, d, err);
      end else begin
        apb_read(a, rd, err, er, ee);
        n_tests++;
        if (rd !== er || err !== ee) begin
          n_fail++;
          $display("FAIL rnd %0d rd %h: got %h err %b need %h err %b", t, a, rd, err, er, ee);
        end
        $display("[TB] rnd %0d rd a=%h d=%h err=%b", t, a, rd, err);
      end
      n_tests++;
      if (timint !== m_timint || irq !== m_irq) begin
        n_fail++;
        $display("FAIL rnd %0d irq: TIMINT %b IRQ %b need %b %b", t, timint, irq, m_timint, m_irq);
      end
      idle($urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_midcount();
    bit err, ee;
    logic [31:0] rd, er;
    apb_write(8'h84, 32'd0, err);
    apb_write(8'h00, 32'd5, err);
    apb_write(8'h08, 32'b011, err);
    apb_write(8'h10, 32'd1, err);
    apb_write(8'h18, 32'b001, err);
    idle(8);
    apb_read(8'h1C, rd, err, er, ee);
    n_tests++;
    if (rd !== 32'd1 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL pre-reset state: RIS1 %h IRQ %b need 1 1", rd, irq);
    end
    bus.PSEL = 1'b1; bus.PWRITE = 1'b1; bus.PADDR = 8'h00; bus.PWDATA = 32'h55; bus.PENABLE = 1'b0;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    check_all_zero("midreset");
  endtask

  initial begin
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0; bus.PWDATA = '0;
    bus2.PSEL = 1'b0; bus2.PENABLE = 1'b0; bus2.PWRITE = 1'b0; bus2.PADDR = '0; bus2.PWDATA = '0;
    @(posedge PCLK); #1;
    test_reset();
    test_periodic();
    test_oneshot();
    test_clear_vs_set();
    test_load_vs_tick();
    test_errors();
    test_masking();
    test_random();
    test_reset_midcount();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
